// File: rtl/irq_ctrl_pkg.sv
// Shared types and route-entry field layout for the interrupt controller.
// The IRQ_CTRL_EDGE_EN build option is consumed by irq_ctrl.sv, not here.
package irq_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } ack_state_e;

  localparam int         ENABLE_BIT   = 7;
  localparam int         MODE_BIT     = 6;
  localparam int         IDX_LSB      = 0;
  localparam int         IDX_W        = 4;
  localparam logic [7:0] VEC_SPURIOUS = 8'hFF;

  typedef struct packed {
    logic             en;
    logic             mode;
    logic [IDX_W-1:0] idx;
  } route_t;

  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
  } nmi_route_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest one.
module irq_prio_enc #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: routes tile INT/NMI requests onto CPU lines and delivers
// fixed-priority vectors in the CPU ack cycle. Define IRQ_CTRL_EDGE_EN for edge-mode sources.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int         NUM_SLOTS       = 3,
  parameter int         NUM_TILE_INT_CH = 2,
  parameter int         NUM_CPU_INT     = 2,
  parameter int         NUM_CPU_NMI     = 1,
  parameter logic [7:0] CFG_BASE        = 8'hC0,
  localparam int        N               = NUM_SLOTS * NUM_TILE_INT_CH,
  localparam int        AW              = (NUM_CPU_INT > 1) ? $clog2(NUM_CPU_INT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [7:0]             cfg_addr,
  input  logic [7:0]             cfg_wdata,
  input  logic [N-1:0]           tile_int_req,
  input  logic [NUM_SLOTS-1:0]   tile_nmi_req,
  input  logic                   irq_vec_cycle,
  input  logic                   irq_ack,
  input  logic [AW-1:0]          ack_line,
  output logic [NUM_CPU_INT-1:0] cpu_int,
  output logic [NUM_CPU_NMI-1:0] cpu_nmi,
  output logic [NUM_SLOTS-1:0]   slot_ack,
  output logic                   vec_valid,
  output logic [7:0]             vec_data
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N > 254 || int'(CFG_BASE) + N + NUM_SLOTS > 255 || NUM_SLOTS < 1 || NUM_SLOTS > 8 ||
      NUM_TILE_INT_CH < 1 || NUM_CPU_INT < 1 || NUM_CPU_INT > 16 ||
      NUM_CPU_NMI < 1 || NUM_CPU_NMI > 16) begin : g_bad_params
    $error("irq_ctrl: illegal parameter combination");
  end

  route_t                 route_q     [N];
  nmi_route_t             nmi_route_q [NUM_SLOTS];
  logic [N-1:0]           req_q, pend, src_act, ack_cand;
  logic [NUM_SLOTS-1:0]   nmi_req_q, nmi_pend_q, nmi_pend_d;
  logic [NUM_CPU_INT-1:0] cpu_int_d;
  logic [NUM_CPU_NMI-1:0] cpu_nmi_d;

  logic [8:0]             cfg_off;
  logic                   cfg_in_win, nmi_clr_wr;
  logic [N-1:0]           route_wr;
  logic [NUM_SLOTS-1:0]   nmi_route_wr;
  route_t                 wr_route;
  nmi_route_t             wr_nmi_route;

  assign cfg_off    = {1'b0, cfg_addr} - {1'b0, CFG_BASE};
  assign cfg_in_win = cfg_we && (cfg_addr >= CFG_BASE);

  always_comb begin
    for (int i = 0; i < N; i++) route_wr[i] = cfg_in_win && (cfg_off == 9'(i));
    for (int s = 0; s < NUM_SLOTS; s++) nmi_route_wr[s] = cfg_in_win && (cfg_off == 9'(N + s));
    nmi_clr_wr = cfg_in_win && (cfg_off == 9'(N + NUM_SLOTS));
  end

  assign wr_route.en      = cfg_wdata[ENABLE_BIT];
`ifdef IRQ_CTRL_EDGE_EN
  assign wr_route.mode    = cfg_wdata[MODE_BIT];
`else
  assign wr_route.mode    = 1'b0;
`endif
  assign wr_route.idx     = cfg_wdata[IDX_LSB +: IDX_W];
  assign wr_nmi_route.en  = cfg_wdata[ENABLE_BIT];
  assign wr_nmi_route.idx = cfg_wdata[IDX_LSB +: IDX_W];

  // pend is only ever set for enabled edge sources, so it needs no mode qualifier here.
  always_comb begin
    cpu_int_d = '0;
    cpu_nmi_d = '0;
    for (int i = 0; i < N; i++) begin
      src_act[i]  = route_q[i].en & ((~route_q[i].mode & req_q[i]) | pend[i]);
      ack_cand[i] = src_act[i] & (route_q[i].idx == IDX_W'(ack_line));
      for (int k = 0; k < NUM_CPU_INT; k++)
        if (src_act[i] && route_q[i].idx == IDX_W'(k)) cpu_int_d[k] = 1'b1;
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      nmi_pend_d[s] = (tile_nmi_req[s] & ~nmi_req_q[s]) |
                      (nmi_pend_q[s] & ~(nmi_clr_wr & cfg_wdata[s]));
      for (int j = 0; j < NUM_CPU_NMI; j++)
        if (nmi_route_q[s].en && nmi_pend_q[s] && nmi_route_q[s].idx == IDX_W'(j))
          cpu_nmi_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) route_q[i] <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) nmi_route_q[s] <= '0;
      req_q      <= '0;
      nmi_req_q  <= '0;
      nmi_pend_q <= '0;
      cpu_int    <= '0;
      cpu_nmi    <= '0;
    end else begin
      for (int i = 0; i < N; i++) if (route_wr[i]) route_q[i] <= wr_route;
      for (int s = 0; s < NUM_SLOTS; s++) if (nmi_route_wr[s]) nmi_route_q[s] <= wr_nmi_route;
      req_q      <= tile_int_req;
      nmi_req_q  <= tile_nmi_req;
      nmi_pend_q <= nmi_pend_d;
      cpu_int    <= cpu_int_d;
      cpu_nmi    <= cpu_nmi_d;
    end
  end

  logic                 enc_found;
  logic [IW-1:0]        enc_idx;
  logic [NUM_SLOTS-1:0] enc_slot_oh;

  irq_prio_enc #(.N(N), .IW(IW)) u_prio_enc (
    .req_i   (ack_cand),
    .found_o (enc_found),
    .idx_o   (enc_idx)
  );

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++)
      enc_slot_oh[s] = ((int'(enc_idx) / NUM_TILE_INT_CH) == s);
  end

  ack_state_e           state_q, state_d;
  logic                 ack_start, ack_done;
  logic                 win_found_q, win_found_d, vec_valid_d;
  logic [IW-1:0]        win_idx_q, win_idx_d;
  logic [NUM_SLOTS-1:0] slot_ack_d;
  logic [7:0]           vec_data_d;

  assign ack_start = (state_q == IDLE) && irq_vec_cycle && irq_ack;
  assign ack_done  = (state_q == GRANT) && !irq_vec_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_found_q <= 1'b0;
      win_idx_q   <= '0;
      vec_valid   <= 1'b0;
      slot_ack    <= '0;
      vec_data    <= '0;
    end else begin
      state_q     <= state_d;
      win_found_q <= win_found_d;
      win_idx_q   <= win_idx_d;
      vec_valid   <= vec_valid_d;
      slot_ack    <= slot_ack_d;
      vec_data    <= vec_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ack_start) state_d = GRANT;
      GRANT:   if (ack_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The winner is captured once on entry; later config writes cannot change it.
  always_comb begin
    win_found_d = win_found_q;
    win_idx_d   = win_idx_q;
    vec_valid_d = vec_valid;
    slot_ack_d  = slot_ack;
    vec_data_d  = vec_data;
    case (state_q)
      IDLE: if (ack_start) begin
        win_found_d = enc_found;
        win_idx_d   = enc_idx;
        vec_valid_d = 1'b1;
        vec_data_d  = enc_found ? 8'(enc_idx) : VEC_SPURIOUS;
        slot_ack_d  = enc_found ? enc_slot_oh : '0;
      end
      GRANT: if (ack_done) begin
        win_found_d = 1'b0;
        vec_valid_d = 1'b0;
        vec_data_d  = '0;
        slot_ack_d  = '0;
      end
      default: ;
    endcase
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [N-1:0] pend_q, pend_d, pend_set, pend_clr;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pend_set[i] = tile_int_req[i] & ~req_q[i] & route_q[i].en & route_q[i].mode;
      pend_clr[i] = (route_wr[i] & ~(wr_route.en & wr_route.mode)) |
                    (ack_done & win_found_q & (win_idx_q == IW'(i)));
    end
    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;

  logic unused_ok;
  assign unused_ok = ^{cfg_wdata[5:4]};
`else
  assign pend = '0;

  logic unused_ok;
  assign unused_ok = ^{cfg_wdata[6:4], win_found_q, win_idx_q, ack_done};
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the routing and acknowledge rules.
module tb_irq_ctrl;
  localparam int NS = 3, CH = 2, NCI = 2, NCN = 1, N = NS * CH, BASE = 'hC0;
`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE_BUILD = 1'b1;
`else
  localparam bit EDGE_BUILD = 1'b0;
`endif

  logic           clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0;
  logic [7:0]     cfg_addr = '0, cfg_wdata = '0;
  logic [N-1:0]   tile_int_req = '0;
  logic [NS-1:0]  tile_nmi_req = '0;
  logic           irq_vec_cycle = 1'b0, irq_ack = 1'b0;
  logic [0:0]     ack_line = '0;
  logic [NCI-1:0] cpu_int;
  logic [NCN-1:0] cpu_nmi;
  logic [NS-1:0]  slot_ack;
  logic           vec_valid;
  logic [7:0]     vec_data;

  int errors = 0, checks = 0;

  irq_ctrl #(.NUM_SLOTS(NS), .NUM_TILE_INT_CH(CH), .NUM_CPU_INT(NCI),
             .NUM_CPU_NMI(NCN), .CFG_BASE(8'hC0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .tile_int_req(tile_int_req), .tile_nmi_req(tile_nmi_req), .irq_vec_cycle(irq_vec_cycle),
    .irq_ack(irq_ack), .ack_line(ack_line), .cpu_int(cpu_int), .cpu_nmi(cpu_nmi),
    .slot_ack(slot_ack), .vec_valid(vec_valid), .vec_data(vec_data));

  always #5 clk = ~clk;

  // Behavioural model state: what each source/slot is configured to and holding.
  bit             m_en [N], m_mode [N], m_pend [N], m_rprev [N];
  int             m_tgt [N];
  bit             m_nen [NS], m_npend [NS], m_nprev [NS];
  int             m_ntgt [NS];
  bit             m_grant;
  int             m_win;
  logic [NCI-1:0] m_int;
  logic [NCN-1:0] m_nmi;
  logic           m_valid;
  logic [7:0]     m_vec;
  logic [NS-1:0]  m_slot;

  function automatic bit asserting(int i);
    return m_en[i] && (m_mode[i] ? m_pend[i] : m_rprev[i]);
  endfunction

  task automatic model_step();
    logic [NCI-1:0] ni;
    logic [NCN-1:0] nn;
    int done_win, off, w;
    bit set, clr;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_mode[i] = 0; m_tgt[i] = 0; m_pend[i] = 0; m_rprev[i] = 0;
      end
      for (int s = 0; s < NS; s++) begin
        m_nen[s] = 0; m_ntgt[s] = 0; m_npend[s] = 0; m_nprev[s] = 0;
      end
      m_grant = 0; m_win = -1; m_int = '0; m_nmi = '0; m_valid = 0; m_vec = '0; m_slot = '0;
      return;
    end
    ni = '0;
    nn = '0;
    for (int k = 0; k < NCI; k++)
      for (int i = 0; i < N; i++) if (asserting(i) && m_tgt[i] == k) ni[k] = 1'b1;
    for (int j = 0; j < NCN; j++)
      for (int s = 0; s < NS; s++) if (m_nen[s] && m_npend[s] && m_ntgt[s] == j) nn[j] = 1'b1;
    done_win = -1;
    if (!m_grant) begin
      if (irq_vec_cycle && irq_ack) begin
        w = -1;
        for (int i = N - 1; i >= 0; i--) if (asserting(i) && m_tgt[i] == int'(ack_line)) w = i;
        m_grant = 1; m_win = w; m_valid = 1;
        m_vec  = (w < 0) ? 8'hFF : 8'(w);
        m_slot = (w < 0) ? '0 : NS'(1 << (w / CH));
      end
    end else if (!irq_vec_cycle) begin
      m_grant = 0; done_win = m_win; m_valid = 0; m_vec = '0; m_slot = '0;
    end
    off = int'(cfg_addr) - BASE;
    for (int i = 0; i < N; i++) begin
      set = EDGE_BUILD && m_en[i] && m_mode[i] && tile_int_req[i] && !m_rprev[i];
      clr = (i == done_win) ||
            (cfg_we && off == i && !(cfg_wdata[7] && cfg_wdata[6]));
      m_pend[i] = set || (m_pend[i] && !clr);
    end
    for (int s = 0; s < NS; s++) begin
      set = tile_nmi_req[s] && !m_nprev[s];
      clr = cfg_we && off == N + NS && cfg_wdata[s];
      m_npend[s] = set || (m_npend[s] && !clr);
    end
    if (cfg_we && off >= 0) begin
      if (off < N) begin
        m_en[off] = cfg_wdata[7]; m_mode[off] = EDGE_BUILD && cfg_wdata[6];
        m_tgt[off] = int'(cfg_wdata[3:0]);
      end else if (off < N + NS) begin
        m_nen[off-N] = cfg_wdata[7]; m_ntgt[off-N] = int'(cfg_wdata[3:0]);
      end
    end
    for (int i = 0; i < N; i++) m_rprev[i] = tile_int_req[i];
    for (int s = 0; s < NS; s++) m_nprev[s] = tile_nmi_req[s];
    m_int = ni;
    m_nmi = nn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (cpu_int !== 2'b00 || cpu_nmi !== 1'b0 || slot_ack !== 3'b000 ||
        vec_valid !== 1'b0 || vec_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: int=%b nmi=%b slot=%b valid=%b vec=%h, want all zero",
               cpu_int, cpu_nmi, slot_ack, vec_valid, vec_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_level();
    cfg_write(8'(BASE + 2), 8'h80);
    tile_int_req[2] = 1'b1;
    tick();
    checks++;
    if (cpu_int !== 2'b00) begin errors++; $display("FAIL level_latency: cpu_int=%b want 00", cpu_int); end
    tick();
    checks++;
    if (cpu_int !== 2'b01) begin errors++; $display("FAIL level_on: cpu_int=%b want 01", cpu_int); end
    tile_int_req[2] = 1'b0;
    tick();
    checks++;
    if (cpu_int !== 2'b01) begin errors++; $display("FAIL level_hold: cpu_int=%b want 01", cpu_int); end
    tick();
    checks++;
    if (cpu_int !== 2'b00) begin errors++; $display("FAIL level_off: cpu_int=%b want 00", cpu_int); end
  endtask

  task automatic test_edge();
    logic [1:0] exp_hold;
    logic [7:0] exp_vec;
    logic [2:0] exp_slot;
`ifdef IRQ_CTRL_EDGE_EN
    exp_hold = 2'b10; exp_vec = 8'h03; exp_slot = 3'b010;
`else
    exp_hold = 2'b00; exp_vec = 8'hFF; exp_slot = 3'b000;
`endif
    cfg_write(8'(BASE + 3), 8'hC1);
    tile_int_req[3] = 1'b1;
    tick();
    tile_int_req[3] = 1'b0;
    tick();
    checks++;
    if (cpu_int !== 2'b10) begin errors++; $display("FAIL edge_first: cpu_int=%b want 10", cpu_int); end
    repeat (3) tick();
    checks++;
    if (cpu_int !== exp_hold) begin errors++; $display("FAIL edge_hold: cpu_int=%b want %b", cpu_int, exp_hold); end
    ack_line = 1'b1; irq_vec_cycle = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (vec_valid !== 1'b1 || vec_data !== exp_vec || slot_ack !== exp_slot) begin
      errors++;
      $display("FAIL edge_ack: valid=%b vec=%h slot=%b want 1 %h %b", vec_valid, vec_data, slot_ack, exp_vec, exp_slot);
    end
    tick();
    checks++;
    if (vec_valid !== 1'b1 || vec_data !== exp_vec || slot_ack !== exp_slot) begin
      errors++;
      $display("FAIL edge_ack_hold: valid=%b vec=%h slot=%b want 1 %h %b", vec_valid, vec_data, slot_ack, exp_vec, exp_slot);
    end
    irq_vec_cycle = 1'b0;
    tick();
    checks++;
    if (vec_valid !== 1'b0 || vec_data !== 8'h00 || slot_ack !== 3'b000) begin
      errors++;
      $display("FAIL edge_ack_end: valid=%b vec=%h slot=%b want 0 00 000", vec_valid, vec_data, slot_ack);
    end
    tick();
    checks++;
    if (cpu_int !== 2'b00) begin errors++; $display("FAIL edge_cleared: cpu_int=%b want 00", cpu_int); end
    cfg_write(8'(BASE + 3), 8'h00);
  endtask

  task automatic test_priority();
    cfg_write(8'(BASE + 1), 8'h80);
    cfg_write(8'(BASE + 4), 8'h80);
    tile_int_req[1] = 1'b1; tile_int_req[4] = 1'b1;
    repeat (2) tick();
    checks++;
    if (cpu_int !== 2'b01) begin errors++; $display("FAIL prio_line: cpu_int=%b want 01", cpu_int); end
    ack_line = 1'b0; irq_vec_cycle = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (vec_data !== 8'h01 || slot_ack !== 3'b001 || vec_valid !== 1'b1) begin
      errors++;
      $display("FAIL prio_first: vec=%h slot=%b valid=%b want 01 001 1", vec_data, slot_ack, vec_valid);
    end
    irq_vec_cycle = 1'b0;
    tick();
    tile_int_req[1] = 1'b0;
    repeat (2) tick();
    irq_vec_cycle = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (vec_data !== 8'h04 || slot_ack !== 3'b100 || vec_valid !== 1'b1) begin
      errors++;
      $display("FAIL prio_second: vec=%h slot=%b valid=%b want 04 100 1", vec_data, slot_ack, vec_valid);
    end
    irq_vec_cycle = 1'b0;
    tick();
    tile_int_req[4] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_spurious();
    ack_line = 1'b0; irq_vec_cycle = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (vec_data !== 8'hFF || vec_valid !== 1'b1 || slot_ack !== 3'b000) begin
      errors++;
      $display("FAIL spurious: vec=%h valid=%b slot=%b want FF 1 000", vec_data, vec_valid, slot_ack);
    end
    tile_int_req[1] = 1'b1;
    repeat (2) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (vec_data !== 8'hFF || slot_ack !== 3'b000) begin
      errors++;
      $display("FAIL grant_ignores_ack: vec=%h slot=%b want FF 000", vec_data, slot_ack);
    end
    irq_vec_cycle = 1'b0;
    tile_int_req[1] = 1'b0;
    tick();
    cfg_write(8'(BASE + 5), 8'h83);
    tile_int_req[5] = 1'b1;
    repeat (3) tick();
    checks++;
    if (cpu_int !== 2'b00) begin errors++; $display("FAIL route_nowhere: cpu_int=%b want 00", cpu_int); end
    tile_int_req[5] = 1'b0;
    tick();
  endtask

  task automatic test_nmi();
    cfg_write(8'(BASE + N + 2), 8'h80);
    tile_nmi_req[2] = 1'b1;
    tick();
    tile_nmi_req[2] = 1'b0;
    tick();
    checks++;
    if (cpu_nmi !== 1'b1) begin errors++; $display("FAIL nmi_on: cpu_nmi=%b want 1", cpu_nmi); end
    repeat (3) tick();
    checks++;
    if (cpu_nmi !== 1'b1) begin errors++; $display("FAIL nmi_held: cpu_nmi=%b want 1", cpu_nmi); end
    cfg_write(8'(BASE + N + 3), 8'h04);
    checks++;
    if (cpu_nmi !== 1'b1) begin errors++; $display("FAIL nmi_clear_latency: cpu_nmi=%b want 1", cpu_nmi); end
    tick();
    checks++;
    if (cpu_nmi !== 1'b0) begin errors++; $display("FAIL nmi_cleared: cpu_nmi=%b want 0", cpu_nmi); end
  endtask

  task automatic test_reset_grant();
    cfg_write(8'(BASE + 3), 8'hC1);
    tile_int_req[3] = 1'b1;
    repeat (2) tick();
    ack_line = 1'b1; irq_vec_cycle = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (vec_valid !== 1'b1 || vec_data !== 8'h03) begin
      errors++;
      $display("FAIL rst_grant_pre: valid=%b vec=%h want 1 03", vec_valid, vec_data);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (cpu_int !== 2'b00 || cpu_nmi !== 1'b0 || slot_ack !== 3'b000 ||
        vec_valid !== 1'b0 || vec_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_grant: int=%b nmi=%b slot=%b valid=%b vec=%h want all zero",
               cpu_int, cpu_nmi, slot_ack, vec_valid, vec_data);
    end
    tile_int_req[3] = 1'b0; irq_vec_cycle = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cfg_write(8'(BASE + 3), 8'hC1);
    repeat (2) tick();
    checks++;
    if (cpu_int !== 2'b00) begin errors++; $display("FAIL rst_pend_cleared: cpu_int=%b want 00", cpu_int); end
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 8'(BASE + int'($urandom_range(0, N + NS + 1)));
      if ($urandom_range(0, 7) == 0) cfg_addr = 8'($urandom);
      cfg_wdata = 8'($urandom);
      if (int'(cfg_addr) >= BASE && int'(cfg_addr) < BASE + N + NS)
        cfg_wdata[3:0] = 4'($urandom_range(0, 2));
      tile_int_req = tile_int_req ^ (N'($urandom) & N'($urandom));
      tile_nmi_req = tile_nmi_req ^ (NS'($urandom) & NS'($urandom));
      if (!irq_vec_cycle) irq_vec_cycle = ($urandom_range(0, 3) == 0);
      else                irq_vec_cycle = ($urandom_range(0, 2) != 0);
      irq_ack  = 1'($urandom_range(0, 1));
      ack_line = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (cpu_int !== m_int || cpu_nmi !== m_nmi || vec_valid !== m_valid ||
          vec_data !== m_vec || slot_ack !== m_slot) begin
        errors++;
        $display("FAIL random cyc %0d: int=%b/%b nmi=%b/%b valid=%b/%b vec=%h/%h slot=%b/%b (got/want)",
                 cyc, cpu_int, m_int, cpu_nmi, m_nmi, vec_valid, m_valid, vec_data, m_vec, slot_ack, m_slot);
      end
    end
    cfg_we = 1'b0; irq_vec_cycle = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_spurious();
    test_nmi();
    test_reset_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
